instr_fetch: RTL

- Front-end fetch unit for the 16-bit CPU. It holds the PC, requests instruction words from instruction memory over a req/ack interface, and buffers them in a small FIFO.
- It presents each word with its 3-bit opcode field to the control decoder using a valid/ready handshake.
- The execute stage drives redirect/redirect_pc when the decoder's jump or a taken branch resolves; on redirect the unit flushes its buffered and in-flight instructions.

---
 rtl/instr_fetch.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit: PC, imem req/ack master, instruction FIFO
// Optional macro FETCH_PERF_EN adds perf_fetched / perf_flushed counters.
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr,
  output logic [2:0]  opcode,
  output logic [15:0] instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] perf_fetched,
  output logic [15:0] perf_flushed
`endif
);

  localparam int             PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [15:0]      pc;
  logic [15:0]      pc_next;
  logic             req_next;
  logic [15:0]      addr_next;

  logic [15:0]      word_mem [DEPTH];
  logic [15:0]      pc_mem   [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_after;
  logic             empty;
  logic             push;
  logic             pop;

  // A push only happens for a live request; redirect turns a landing ack into a discard.
  assign empty       = (count == '0);
  assign instr_valid = !empty;
  assign pop         = instr_valid && instr_ready;
  assign push        = (state == S_WAIT) && imem_ack && !redirect;
  assign count_after = count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

  assign instr    = empty ? 16'h0000 : word_mem[rd_ptr];
  assign instr_pc = empty ? 16'h0000 : pc_mem[rd_ptr];
  assign opcode   = instr[15:13];

  // Next fetch PC: redirect wins, otherwise advance on every accepted word (wraps at 16 bits).
  always_comb begin
    pc_next = pc;
    if (redirect) begin
      pc_next = redirect_pc;
    end else if (push) begin
      pc_next = pc + 16'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state; a new request is only issued when the FIFO has room for its word.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (!redirect && (count < DEPTH_C)) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          state_next = imem_ack ? S_IDLE : S_DROP;
        end else if (imem_ack) begin
          state_next = (count_after < DEPTH_C) ? S_WAIT : S_IDLE;
        end
      end
      S_DROP: begin
        // The stale request must still complete; a redirect here only moves the PC.
        if (imem_ack) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs: request follows the next state; address is reloaded only when a new request starts.
  always_comb begin
    req_next  = (state_next != S_IDLE);
    addr_next = imem_addr;
    if ((state_next == S_WAIT) && ((state == S_IDLE) || imem_ack)) begin
      addr_next = pc_next;
    end
  end

  // Registered request interface and PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      pc        <= RESET_PC;
    end else begin
      imem_req  <= req_next;
      imem_addr <= addr_next;
      pc        <= pc_next;
    end
  end

  // FIFO pointers and occupancy; redirect flushes everything, including a same-cycle pop.
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_after;
    end
  end

  // FIFO storage: word plus the address it was fetched from.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      word_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= imem_addr;
    end
  end

`ifdef FETCH_PERF_EN
  logic flush_hit;

  assign flush_hit = redirect && (!empty || (state == S_WAIT));

  // Saturating counters for delivered instructions and redirects that threw work away.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= 16'h0000;
      perf_flushed <= 16'h0000;
    end else begin
      if (pop && !redirect && (perf_fetched != 16'hFFFF)) begin
        perf_fetched <= perf_fetched + 16'd1;
      end
      if (flush_hit && (perf_flushed != 16'hFFFF)) begin
        perf_flushed <= perf_flushed + 16'd1;
      end
    end
  end
`endif

endmodule
